// File: rtl/psrv32_pkg.sv
// ============================================================================
// psrv32_pkg : shared widths and constants for the operand fetch stage
// Revision   : 1.0
// ============================================================================
`default_nettype none

package psrv32_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREG       = 32;
    localparam logic [REG_ADDR_W-1:0] X0_IDX = '0;
endpackage

`default_nettype wire

// File: rtl/operand_fetch_regfile_2r1w.sv
// ============================================================================
// regfile_2r1w : two asynchronous read ports, one synchronous write port,
//                x0 reads as zero and ignores writes
// Revision     : 1.0
// ============================================================================
`default_nettype none

module regfile_2r1w #(
    parameter int XLEN = psrv32_pkg::XLEN,
    parameter int NREG = psrv32_pkg::NREG
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                we_i,
    input  logic [psrv32_pkg::REG_ADDR_W-1:0]   waddr_i,
    input  logic [XLEN-1:0]                     wdata_i,
    input  logic [psrv32_pkg::REG_ADDR_W-1:0]   raddr1_i,
    output logic [XLEN-1:0]                     rdata1_o,
    input  logic [psrv32_pkg::REG_ADDR_W-1:0]   raddr2_i,
    output logic [XLEN-1:0]                     rdata2_o
);
    import psrv32_pkg::*;

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];

    always_comb begin
        mem_d = mem_q;
        if (we_i && (waddr_i != X0_IDX)) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata1_o = (raddr1_i == X0_IDX) ? '0 : mem_q[raddr1_i];
    assign rdata2_o = (raddr2_i == X0_IDX) ? '0 : mem_q[raddr2_i];

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// operand_fetch : register read with writeback bypass, pending-write
//                 scoreboard and a one-entry valid/ready output register
// Revision      : 1.0
// ============================================================================
`default_nettype none

module operand_fetch #(
    parameter int XLEN = psrv32_pkg::XLEN,
    parameter int NREG = psrv32_pkg::NREG
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                id_valid_i,
    output logic                                id_ready_o,
    input  logic [psrv32_pkg::REG_ADDR_W-1:0]   rs1_i,
    input  logic [psrv32_pkg::REG_ADDR_W-1:0]   rs2_i,
    input  logic [psrv32_pkg::REG_ADDR_W-1:0]   rd_i,
    input  logic                                rd_we_i,
    input  logic                                wb_we_i,
    input  logic [psrv32_pkg::REG_ADDR_W-1:0]   wb_rd_i,
    input  logic [XLEN-1:0]                     wb_data_i,
    output logic                                ex_valid_o,
    input  logic                                ex_ready_i,
    output logic [XLEN-1:0]                     rs1_data_o,
    output logic [XLEN-1:0]                     rs2_data_o,
    output logic [psrv32_pkg::REG_ADDR_W-1:0]   ex_rd_o,
    output logic                                ex_rd_we_o
);
    import psrv32_pkg::*;

    logic [XLEN-1:0]       rf_rs1;
    logic [XLEN-1:0]       rf_rs2;
    logic [XLEN-1:0]       rs1_val;
    logic [XLEN-1:0]       rs2_val;
    logic [NREG-1:0]       pending_q, pending_d;
    logic [NREG-1:0]       clr_mask, set_mask, eff_pending;
    logic                  hazard;
    logic                  accept;

    logic                  ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]       rs2_data_q, rs2_data_d;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic                  ex_rd_we_q, ex_rd_we_d;

    regfile_2r1w #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .we_i     (wb_we_i),
        .waddr_i  (wb_rd_i),
        .wdata_i  (wb_data_i),
        .raddr1_i (rs1_i),
        .rdata1_o (rf_rs1),
        .raddr2_i (rs2_i),
        .rdata2_o (rf_rs2)
    );

    // A register being written back this cycle is already resolved.
    always_comb begin
        clr_mask = '0;
        if (wb_we_i && (wb_rd_i != X0_IDX)) begin
            clr_mask[wb_rd_i] = 1'b1;
        end
        eff_pending = pending_q & ~clr_mask;
        hazard = ((rs1_i != X0_IDX) && eff_pending[rs1_i])
              || ((rs2_i != X0_IDX) && eff_pending[rs2_i])
              || (rd_we_i && (rd_i != X0_IDX) && eff_pending[rd_i]);
    end

    assign id_ready_o = !hazard && (!ex_valid_q || ex_ready_i);
    assign accept     = id_valid_i && id_ready_o;

    always_comb begin
        rs1_val = rf_rs1;
        if (rs1_i == X0_IDX) begin
            rs1_val = '0;
        end else if (wb_we_i && (wb_rd_i == rs1_i)) begin
            rs1_val = wb_data_i;
        end
        rs2_val = rf_rs2;
        if (rs2_i == X0_IDX) begin
            rs2_val = '0;
        end else if (wb_we_i && (wb_rd_i == rs2_i)) begin
            rs2_val = wb_data_i;
        end
    end

    // OR-ing the set after the clear lets a new issue win over a same-cycle writeback.
    always_comb begin
        set_mask = '0;
        if (accept && rd_we_i && (rd_i != X0_IDX)) begin
            set_mask[rd_i] = 1'b1;
        end
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        ex_rd_d    = ex_rd_q;
        ex_rd_we_d = ex_rd_we_q;
        if (accept) begin
            ex_valid_d = 1'b1;
            rs1_data_d = rs1_val;
            rs2_data_d = rs2_val;
            ex_rd_d    = rd_i;
            ex_rd_we_d = rd_we_i;
        end else if (ex_ready_i) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pending_q  <= '0;
            ex_valid_q <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            ex_rd_q    <= '0;
            ex_rd_we_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            ex_valid_q <= ex_valid_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            ex_rd_q    <= ex_rd_d;
            ex_rd_we_q <= ex_rd_we_d;
        end
    end

    assign ex_valid_o = ex_valid_q;
    assign rs1_data_o = rs1_data_q;
    assign rs2_data_o = rs2_data_q;
    assign ex_rd_o    = ex_rd_q;
    assign ex_rd_we_o = ex_rd_we_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// tb_operand_fetch : directed and randomized checks of operand_fetch against
//                    an array-based reference model
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_operand_fetch;
    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic            id_valid_i;
    logic            id_ready_o;
    logic [4:0]      rs1_i, rs2_i, rd_i;
    logic            rd_we_i;
    logic            wb_we_i;
    logic [4:0]      wb_rd_i;
    logic [XLEN-1:0] wb_data_i;
    logic            ex_valid_o;
    logic            ex_ready_i;
    logic [XLEN-1:0] rs1_data_o, rs2_data_o;
    logic [4:0]      ex_rd_o;
    logic            ex_rd_we_o;

    int errors = 0;
    int checks = 0;

    logic [XLEN-1:0] m_regs [32];
    bit              m_pend [32];
    bit              m_valid;
    logic [XLEN-1:0] m_rs1d, m_rs2d;
    logic [4:0]      m_rd;
    bit              m_we;

    operand_fetch #(.XLEN(XLEN), .NREG(32)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .id_valid_i (id_valid_i),
        .id_ready_o (id_ready_o),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .rd_i       (rd_i),
        .rd_we_i    (rd_we_i),
        .wb_we_i    (wb_we_i),
        .wb_rd_i    (wb_rd_i),
        .wb_data_i  (wb_data_i),
        .ex_valid_o (ex_valid_o),
        .ex_ready_i (ex_ready_i),
        .rs1_data_o (rs1_data_o),
        .rs2_data_o (rs2_data_o),
        .ex_rd_o    (ex_rd_o),
        .ex_rd_we_o (ex_rd_we_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    function automatic bit busy(input logic [4:0] r);
        return (r != 0) && m_pend[r] && !(wb_we_i && wb_rd_i == r);
    endfunction

    function automatic bit exp_ready();
        bit hz;
        hz = busy(rs1_i) || busy(rs2_i) || (rd_we_i && busy(rd_i));
        return !hz && (!m_valid || ex_ready_i);
    endfunction

    function automatic logic [XLEN-1:0] rd_val(input logic [4:0] r);
        if (r == 0) return '0;
        if (wb_we_i && wb_rd_i == r) return wb_data_i;
        return m_regs[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 0;
        end
        m_valid = 0; m_rs1d = '0; m_rs2d = '0; m_rd = '0; m_we = 0;
    endtask

    // Advance model and DUT by one clock; returns at negedge + 1.
    task automatic tick();
        bit acc;
        logic [XLEN-1:0] v1, v2;
        acc = id_valid_i && exp_ready();
        v1 = rd_val(rs1_i);
        v2 = rd_val(rs2_i);
        if (acc) begin
            m_valid = 1; m_rs1d = v1; m_rs2d = v2; m_rd = rd_i; m_we = rd_we_i;
        end else if (ex_ready_i) begin
            m_valid = 0;
        end
        if (wb_we_i && wb_rd_i != 0) begin
            m_regs[wb_rd_i] = wb_data_i;
            m_pend[wb_rd_i] = 0;
        end
        if (acc && rd_we_i && rd_i != 0) m_pend[rd_i] = 1;
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
    endtask

    task automatic idle();
        id_valid_i = 0; rs1_i = 0; rs2_i = 0; rd_i = 0; rd_we_i = 0;
        wb_we_i = 0; wb_rd_i = 0; wb_data_i = '0; ex_ready_i = 1;
    endtask

    task automatic issue(input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input bit we);
        id_valid_i = 1; rs1_i = a; rs2_i = b; rd_i = d; rd_we_i = we;
    endtask

    task automatic writeback(input logic [4:0] r, input logic [XLEN-1:0] v);
        wb_we_i = 1; wb_rd_i = r; wb_data_i = v;
    endtask

    // Writes every register once, which also retires all pending bits.
    task automatic drain();
        idle();
        for (int r = 1; r < 32; r++) begin
            writeback(5'(r), $urandom);
            tick();
        end
        idle();
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        ex_ready_i = 0;
        reset_i = 0;
        model_reset();
        #1;
        checks++;
        if (ex_valid_o !== 1'b0 || rs1_data_o !== '0 || rs2_data_o !== '0 ||
            ex_rd_o !== '0 || ex_rd_we_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b rs1=%h rs2=%h rd=%0d we=%b, required all zero",
                     ex_valid_o, rs1_data_o, rs2_data_o, ex_rd_o, ex_rd_we_o);
        end
        checks++;
        if (id_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", id_ready_o);
        end
        repeat (2) @(negedge clk_i);
        #1;
        reset_i = 1;
        idle();
        #1;
    endtask

    task automatic test_write_read();
        idle();
        writeback(5, 32'h0000_00AA);
        tick();
        idle();
        issue(5, 0, 0, 0);
        #1;
        tick();
        idle();
        checks++;
        if (ex_valid_o !== 1'b1 || rs1_data_o !== 32'hAA || rs2_data_o !== '0) begin
            errors++;
            $display("FAIL write_read: valid=%b rs1=%h rs2=%h required 1/000000aa/0",
                     ex_valid_o, rs1_data_o, rs2_data_o);
        end
        // Same-cycle bypass on rs2
        issue(0, 6, 0, 0);
        writeback(6, 32'h5555_0066);
        tick();
        idle();
        checks++;
        if (rs2_data_o !== 32'h5555_0066 || rs1_data_o !== '0) begin
            errors++;
            $display("FAIL bypass: rs1=%h rs2=%h required 0/55550066", rs1_data_o, rs2_data_o);
        end
    endtask

    task automatic test_x0();
        idle();
        writeback(0, 32'hDEAD_BEEF);
        tick();
        idle();
        issue(0, 0, 0, 0);
        writeback(0, 32'hDEAD_BEEF);
        tick();
        idle();
        checks++;
        if (ex_valid_o !== 1'b1 || rs1_data_o !== '0 || rs2_data_o !== '0) begin
            errors++;
            $display("FAIL x0_read: valid=%b rs1=%h rs2=%h required 1/0/0",
                     ex_valid_o, rs1_data_o, rs2_data_o);
        end
    endtask

    task automatic test_raw();
        idle();
        issue(0, 0, 7, 1);
        tick();
        issue(7, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (id_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL raw_stall: cycle %0d id_ready=%b required 0", i, id_ready_o);
            end
            tick();
        end
        writeback(7, 32'h1234);
        #1;
        checks++;
        if (id_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL raw_release: id_ready=%b required 1", id_ready_o);
        end
        tick();
        idle();
        checks++;
        if (ex_valid_o !== 1'b1 || rs1_data_o !== 32'h1234) begin
            errors++;
            $display("FAIL raw_data: valid=%b rs1=%h required 1/00001234", ex_valid_o, rs1_data_o);
        end
    endtask

    task automatic test_waw();
        idle();
        issue(0, 0, 9, 1);
        tick();
        issue(0, 0, 9, 1);
        #1;
        checks++;
        if (id_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL waw_stall: id_ready=%b required 0", id_ready_o);
        end
        tick();
        writeback(9, 32'h0000_0999);
        #1;
        checks++;
        if (id_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL waw_release: id_ready=%b required 1", id_ready_o);
        end
        tick();
        idle();
        issue(9, 0, 0, 0);
        #1;
        checks++;
        if (id_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL set_wins: id_ready=%b required 0 (x9 still pending)", id_ready_o);
        end
        idle();
        writeback(9, 32'h0000_0AAA);
        tick();
        idle();
    endtask

    task automatic test_backpressure();
        logic [XLEN-1:0] h1, h2;
        idle();
        writeback(11, 32'hCAFE_0011);
        tick();
        idle();
        ex_ready_i = 0;
        issue(11, 0, 12, 0);
        tick();
        h1 = rs1_data_o;
        h2 = rs2_data_o;
        issue(0, 11, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (id_ready_o !== 1'b0 || ex_valid_o !== 1'b1 || rs1_data_o !== 32'hCAFE_0011 ||
                rs1_data_o !== h1 || rs2_data_o !== h2 || ex_rd_o !== 5'd12) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d ready=%b valid=%b rs1=%h rd=%0d required 0/1/cafe0011/12",
                         i, id_ready_o, ex_valid_o, rs1_data_o, ex_rd_o);
            end
            tick();
        end
        ex_ready_i = 1;
        #1;
        checks++;
        if (id_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: id_ready=%b required 1", id_ready_o);
        end
        tick();
        idle();
        checks++;
        if (ex_valid_o !== 1'b1 || rs2_data_o !== 32'hCAFE_0011 || rs1_data_o !== '0) begin
            errors++;
            $display("FAIL no_bubble: valid=%b rs1=%h rs2=%h required 1/0/cafe0011",
                     ex_valid_o, rs1_data_o, rs2_data_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] a, b;
        drain();
        for (int i = 0; i < 10; i++) begin
            a = 5'($urandom_range(0, 31));
            b = 5'($urandom_range(0, 31));
            issue(a, b, 5'($urandom_range(1, 31)), 0);
            #1;
            checks++;
            if (id_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready: beat %0d id_ready=%b required 1", i, id_ready_o);
            end
            tick();
            checks++;
            if (ex_valid_o !== 1'b1 || rs1_data_o !== m_rs1d || rs2_data_o !== m_rs2d) begin
                errors++;
                $display("FAIL b2b_data: beat %0d valid=%b rs1=%h rs2=%h required 1/%h/%h",
                         i, ex_valid_o, rs1_data_o, rs2_data_o, m_rs1d, m_rs2d);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            id_valid_i = ($urandom_range(0, 3) != 0);
            rs1_i      = 5'($urandom_range(0, 7));
            rs2_i      = 5'($urandom_range(0, 7));
            rd_i       = 5'($urandom_range(0, 7));
            rd_we_i    = $urandom_range(0, 1) == 1;
            wb_we_i    = $urandom_range(0, 1) == 1;
            wb_rd_i    = 5'($urandom_range(0, 7));
            wb_data_i  = $urandom;
            ex_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (id_ready_o !== exp_ready()) begin
                errors++;
                $display("FAIL rand_ready: iter %0d got %b required %b", i, id_ready_o, exp_ready());
            end
            tick();
            checks++;
            if (ex_valid_o !== m_valid || rs1_data_o !== m_rs1d || rs2_data_o !== m_rs2d ||
                ex_rd_o !== m_rd || ex_rd_we_o !== m_we) begin
                errors++;
                $display("FAIL rand_out: iter %0d got v=%b %h %h rd=%0d we=%b required v=%b %h %h rd=%0d we=%b",
                         i, ex_valid_o, rs1_data_o, rs2_data_o, ex_rd_o, ex_rd_we_o,
                         m_valid, m_rs1d, m_rs2d, m_rd, m_we);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        ex_ready_i = 0;
        issue(0, 0, 3, 1);
        tick();
        idle();
        ex_ready_i = 0;
        checks++;
        if (ex_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: valid=%b required 1", ex_valid_o);
        end
        #1;
        reset_i = 0;
        model_reset();
        #1;
        checks++;
        if (ex_valid_o !== 1'b0 || ex_rd_o !== '0 || ex_rd_we_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: valid=%b rd=%0d we=%b required 0/0/0",
                     ex_valid_o, ex_rd_o, ex_rd_we_o);
        end
        @(negedge clk_i);
        #1;
        reset_i = 1;
        idle();
        issue(3, 0, 0, 0);
        #1;
        checks++;
        if (id_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_no_stall: id_ready=%b required 1", id_ready_o);
        end
        tick();
        idle();
        checks++;
        if (ex_valid_o !== 1'b1 || rs1_data_o !== '0) begin
            errors++;
            $display("FAIL mid_read_zero: valid=%b rs1=%h required 1/0", ex_valid_o, rs1_data_o);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_x0();
        test_raw();
        test_waw();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter XLEN, default 32: datapath width.
REQ-002 Parameter NREG, default 32: architectural register count; x0 is hardwired to zero.
REQ-003 Ports, in order: clk_i (in, 1): the only clock, rising-edge; reset_i (in, 1): asynchronous, active-low reset.
REQ-004 id_valid_i  in  1: decode presents an instruction.
REQ-005 id_ready_o  out  1: stage accepts the instruction this cycle.
REQ-006 rs1_i, rs2_i  in  5 each: source register indices.
REQ-007 rd_i  in  5; rd_we_i  in  1: destination register index and its write enable.
REQ-008 wb_we_i  in  1; wb_rd_i  in  5; wb_data_i  in  XLEN: write port driven by the writeback stage (its mux output).
REQ-009 ex_valid_o  out  1; ex_ready_i  in  1: output handshake to execute.
REQ-010 rs1_data_o, rs2_data_o  out  XLEN; ex_rd_o  out  5; ex_rd_we_o  out  1: registered operands and destination.

Function
REQ-011 Register file: x1..x31 written on the rising edge when wb_we_i=1 and wb_rd_i!=0; writes to x0 are discarded.
REQ-012 Read value for index r: 0 if r=0; wb_data_i if wb_we_i=1 and wb_rd_i=r (same-cycle bypass); otherwise the stored value.
REQ-013 Scoreboard: one pending bit per register; x0 is never pending.
REQ-014 Hazard is asserted when either of the following holds; a pending bit being cleared this cycle by wb_we_i/wb_rd_i does not count.
  - A nonzero rs1_i or rs2_i is pending.
  - rd_we_i=1, rd_i!=0 and rd_i is pending (WAW).
REQ-015 id_ready_o = !hazard && (!ex_valid_o || ex_ready_i); purely combinational, no dependency on id_valid_i.
REQ-016 Accept = id_valid_i && id_ready_o. On accept, the output registers load the REQ-012 values, rd_i and rd_we_i, and ex_valid_o=1 the next cycle (latency 1).
REQ-017 ex_valid_o and the output data hold stable while ex_valid_o=1 and ex_ready_i=0.
REQ-018 ex_valid_o clears when ex_ready_i=1 and there is no accept in the same cycle.
REQ-019 Pending bit set on accept with rd_we_i=1, rd_i!=0; cleared on wb_we_i=1 for wb_rd_i.
REQ-020 If set and clear hit the same index in one cycle, set wins.
REQ-021 A writeback to a non-pending register still updates the register file and leaves the scoreboard unchanged.
REQ-022 Full throughput: back-to-back independent instructions accept every cycle while ex_ready_i=1.

Reset
REQ-023 While reset_i=0, asynchronously:
  - x1..x31 = 0; all pending bits = 0;
  - ex_valid_o = 0; rs1_data_o, rs2_data_o, ex_rd_o, ex_rd_we_o = 0;
  - id_ready_o then follows REQ-015 (=1).
REQ-024 Reset asserted mid-operation discards the in-flight output and all pending bits; no write occurs on the reset edge.

Structure
REQ-025 Package psrv32_pkg holds XLEN, REG_ADDR_W (5), NREG and the x0 index constant.
REQ-026 Sub-module regfile_2r1w (two async read ports, one sync write port, x0 hardwired) holds the storage; scoreboard, bypass and handshake logic stay in operand_fetch.

Verification
REQ-027 Write x5=0x0000_00AA via writeback, then issue rs1=5, rs2=0 -> next cycle rs1_data_o=0xAA, rs2_data_o=0, ex_valid_o=1.
REQ-028 Writeback wb_rd_i=0, wb_data_i=0xDEAD_BEEF, then read x0 -> 0.
REQ-029 Issue rd=7 with rd_we_i=1, then rs1=7 -> id_ready_o=0 until the cycle wb_we_i=1, wb_rd_i=7, wb_data_i=0x1234 -> accepted that cycle, rs1_data_o=0x1234 next cycle.
REQ-030 Issue rd=9 twice -> second held off (WAW) until x9 writeback; same-cycle set/clear of x9 -> pending stays 1.
REQ-031 ex_ready_i=0 for 3 cycles with ex_valid_o=1 -> outputs stable, id_ready_o=0; ex_ready_i=1 with new id_valid_i -> accept, no bubble.
REQ-032 Pending x3, ex_valid_o=1, assert reset_i=0 mid-cycle -> ex_valid_o=0 immediately; after release, rs1=3 is accepted without stall and reads 0.
